// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared core defines for the register file, RoB, dispatcher and RS/LSB
//
// Purpose: architectural constants (RoB index width, register count, x0 index)
//          and small helpers shared by every core block.
// Ports:   none (package).
package register_file_pkg;

    localparam int ROB_WIDTH = 3;
    localparam int REG_WIDTH = 5;
    localparam int NUM_REGS  = 32;
    localparam int X0_IDX    = 0;
    localparam int XLEN      = 32;

    typedef logic [XLEN-1:0] word_t;

    // Every consumer in the core treats x0 as hard-wired zero.
    function automatic logic is_x0(input logic [REG_WIDTH-1:0] idx);
        return idx == REG_WIDTH'(X0_IDX);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - commit, rename and operand-read bundle of the register file
//
// Purpose: groups the RoB commit port, the dispatcher rename port and the two
//          operand read ports.
// Modports: master - dispatcher/RoB side (drives requests, receives operands)
//           slave  - register file side
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH,
    parameter int REG_WIDTH = register_file_pkg::REG_WIDTH
);
    logic                 commit_valid_in;
    logic [REG_WIDTH-1:0] commit_rd_in;
    word_t                commit_value_in;
    logic [RoB_WIDTH-1:0] commit_rob_id_in;

    logic                 rename_valid_in;
    logic [REG_WIDTH-1:0] rename_rd_in;
    logic [RoB_WIDTH-1:0] rename_rob_id_in;

    logic [REG_WIDTH-1:0] rs1_in;
    logic [REG_WIDTH-1:0] rs2_in;
    word_t                rs1_value_out;
    word_t                rs2_value_out;
    logic                 rs1_busy_out;
    logic                 rs2_busy_out;
    logic [RoB_WIDTH-1:0] rs1_tag_out;
    logic [RoB_WIDTH-1:0] rs2_tag_out;

    modport master (
        output commit_valid_in, commit_rd_in, commit_value_in, commit_rob_id_in,
        output rename_valid_in, rename_rd_in, rename_rob_id_in,
        output rs1_in, rs2_in,
        input  rs1_value_out, rs2_value_out, rs1_busy_out, rs2_busy_out,
        input  rs1_tag_out, rs2_tag_out
    );

    modport slave (
        input  commit_valid_in, commit_rd_in, commit_value_in, commit_rob_id_in,
        input  rename_valid_in, rename_rd_in, rename_rob_id_in,
        input  rs1_in, rs2_in,
        output rs1_value_out, rs2_value_out, rs1_busy_out, rs2_busy_out,
        output rs1_tag_out, rs2_tag_out
    );

endinterface

// File: rtl/register_file_reg_read_port.sv
// rtl/register_file_reg_read_port.sv - one operand lookup with same-cycle commit forwarding
//
// Purpose: looks up value/busy/tag of rs and, if the RoB is committing the
//          exact producer of that operand this cycle, forwards the committed value.
// Ports:   rdy_in                      global enable (commit only counts when high)
//          rs_in                       source register index
//          value_arr_in/busy_arr_in/tag_arr_in  current register state
//          commit_*_in                 RoB commit port
//          value_out/busy_out/tag_out  operand result
module reg_read_port
    import register_file_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH,
    parameter int REG_WIDTH = register_file_pkg::REG_WIDTH,
    localparam int NREGS    = 2 ** REG_WIDTH
) (
    input  logic                 rdy_in,
    input  logic [REG_WIDTH-1:0] rs_in,
    input  word_t                value_arr_in [NREGS],
    input  logic [NREGS-1:0]     busy_arr_in,
    input  logic [RoB_WIDTH-1:0] tag_arr_in [NREGS],
    input  logic                 commit_valid_in,
    input  logic [REG_WIDTH-1:0] commit_rd_in,
    input  word_t                commit_value_in,
    input  logic [RoB_WIDTH-1:0] commit_rob_id_in,
    output word_t                value_out,
    output logic                 busy_out,
    output logic [RoB_WIDTH-1:0] tag_out
);

    logic fwd;

    // Forward only when the commit resolves the rename this operand waits on;
    // a stale commit (older tag) must not wake the reader.
    assign fwd = rdy_in && commit_valid_in && (commit_rd_in == rs_in) && !is_x0(rs_in)
                 && busy_arr_in[rs_in] && (tag_arr_in[rs_in] == commit_rob_id_in);

    always_comb begin
        value_out = value_arr_in[rs_in];
        busy_out  = busy_arr_in[rs_in];
        tag_out   = tag_arr_in[rs_in];
        if (fwd) begin
            value_out = commit_value_in;
            busy_out  = 1'b0;
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with per-register rename tags
//
// Purpose: 32 x 32-bit values plus busy bit and RoB tag per register. The
//          dispatcher renames destinations, the RoB commits results, and a
//          flush drops every in-flight rename.
// Ports:   clk_in    clock, rising edge
//          rst_in    synchronous active-high reset
//          rdy_in    global enable; low freezes all state
//          flush_in  misprediction flush, clears all busy bits
//          rf        register_file_if.slave (commit, rename, two read ports)
module register_file
    import register_file_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH,
    parameter int REG_WIDTH = register_file_pkg::REG_WIDTH
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           flush_in,
    register_file_if.slave rf
);

    localparam int NREGS = 2 ** REG_WIDTH;

    word_t                value_q [NREGS];
    word_t                value_d [NREGS];
    logic [NREGS-1:0]     busy_q;
    logic [NREGS-1:0]     busy_d;
    logic [RoB_WIDTH-1:0] tag_q   [NREGS];
    logic [RoB_WIDTH-1:0] tag_d   [NREGS];

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        // x0 is skipped so it keeps its reset value of all zeros forever.
        for (int i = 1; i < NREGS; i++) begin
            if (rdy_in) begin
                if (rf.commit_valid_in && rf.commit_rd_in == REG_WIDTH'(i)) begin
                    value_d[i] = rf.commit_value_in;
                end
                if (flush_in) begin
                    // Tags are left stale; busy=0 makes them irrelevant.
                    busy_d[i] = 1'b0;
                end else if (rf.rename_valid_in && rf.rename_rd_in == REG_WIDTH'(i)) begin
                    // A same-cycle rename wins over any commit's busy clear.
                    busy_d[i] = 1'b1;
                    tag_d[i]  = rf.rename_rob_id_in;
                end else if (rf.commit_valid_in && rf.commit_rd_in == REG_WIDTH'(i)
                             && tag_q[i] == rf.commit_rob_id_in) begin
                    busy_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    reg_read_port #(.RoB_WIDTH(RoB_WIDTH), .REG_WIDTH(REG_WIDTH)) u_rs1 (
        .rdy_in           (rdy_in),
        .rs_in            (rf.rs1_in),
        .value_arr_in     (value_q),
        .busy_arr_in      (busy_q),
        .tag_arr_in       (tag_q),
        .commit_valid_in  (rf.commit_valid_in),
        .commit_rd_in     (rf.commit_rd_in),
        .commit_value_in  (rf.commit_value_in),
        .commit_rob_id_in (rf.commit_rob_id_in),
        .value_out        (rf.rs1_value_out),
        .busy_out         (rf.rs1_busy_out),
        .tag_out          (rf.rs1_tag_out)
    );

    reg_read_port #(.RoB_WIDTH(RoB_WIDTH), .REG_WIDTH(REG_WIDTH)) u_rs2 (
        .rdy_in           (rdy_in),
        .rs_in            (rf.rs2_in),
        .value_arr_in     (value_q),
        .busy_arr_in      (busy_q),
        .tag_arr_in       (tag_q),
        .commit_valid_in  (rf.commit_valid_in),
        .commit_rd_in     (rf.commit_rd_in),
        .commit_value_in  (rf.commit_value_in),
        .commit_rob_id_in (rf.commit_rob_id_in),
        .value_out        (rf.rs2_value_out),
        .busy_out         (rf.rs2_busy_out),
        .tag_out          (rf.rs2_tag_out)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush_in;

    int n_assert = 0;
    int n_fail   = 0;

    register_file_if rf ();

    register_file dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .rf       (rf)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic idle();
        rf.commit_valid_in  = 1'b0;
        rf.commit_rd_in     = '0;
        rf.commit_value_in  = '0;
        rf.commit_rob_id_in = '0;
        rf.rename_valid_in  = 1'b0;
        rf.rename_rd_in     = '0;
        rf.rename_rob_id_in = '0;
        flush_in            = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [2:0] id);
        rf.rename_valid_in  = 1'b1;
        rf.rename_rd_in     = rd;
        rf.rename_rob_id_in = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [2:0] id, input logic [31:0] v);
        rf.commit_valid_in  = 1'b1;
        rf.commit_rd_in     = rd;
        rf.commit_rob_id_in = id;
        rf.commit_value_in  = v;
    endtask

    initial begin
        idle();
        rdy_in    = 1'b1;
        rst_in    = 1'b1;
        rf.rs1_in = 5'd5;
        rf.rs2_in = 5'd0;
        step();
        rst_in = 1'b0;
        #1;
        chk("reset_rs1_value", rf.rs1_value_out, 32'h0);
        chk("reset_rs1_busy",  32'(rf.rs1_busy_out), 32'h0);
        chk("reset_rs1_tag",   32'(rf.rs1_tag_out), 32'h0);
        chk("reset_rs2_value", rf.rs2_value_out, 32'h0);
        chk("reset_rs2_busy",  32'(rf.rs2_busy_out), 32'h0);
        chk("reset_rs2_tag",   32'(rf.rs2_tag_out), 32'h0);

        // Rename x3 -> tag 2, then commit it with forwarding.
        rename(5'd3, 3'd2);
        step();
        idle();
        rf.rs1_in = 5'd3;
        #1;
        chk("ren_x3_busy", 32'(rf.rs1_busy_out), 32'h1);
        chk("ren_x3_tag",  32'(rf.rs1_tag_out), 32'h2);
        commit(5'd3, 3'd2, 32'hDEADBEEF);
        #1;
        chk("fwd_x3_busy",  32'(rf.rs1_busy_out), 32'h0);
        chk("fwd_x3_value", rf.rs1_value_out, 32'hDEADBEEF);
        step();
        idle();
        #1;
        chk("com_x3_busy",  32'(rf.rs1_busy_out), 32'h0);
        chk("com_x3_value", rf.rs1_value_out, 32'hDEADBEEF);

        // Stale commit on x7.
        rename(5'd7, 3'd1);
        step();
        rename(5'd7, 3'd4);
        step();
        idle();
        commit(5'd7, 3'd1, 32'h11);
        rf.rs1_in = 5'd7;
        #1;
        chk("stale_nofwd_busy", 32'(rf.rs1_busy_out), 32'h1);
        step();
        idle();
        #1;
        chk("stale_x7_value", rf.rs1_value_out, 32'h11);
        chk("stale_x7_busy",  32'(rf.rs1_busy_out), 32'h1);
        chk("stale_x7_tag",   32'(rf.rs1_tag_out), 32'h4);
        commit(5'd7, 3'd4, 32'h22);
        #1;
        chk("fwd_x7_busy",  32'(rf.rs1_busy_out), 32'h0);
        chk("fwd_x7_value", rf.rs1_value_out, 32'h22);
        step();
        idle();
        #1;
        chk("com_x7_busy",  32'(rf.rs1_busy_out), 32'h0);
        chk("com_x7_value", rf.rs1_value_out, 32'h22);

        // Commit and rename of x9 in the same cycle.
        rename(5'd9, 3'd3);
        step();
        idle();
        commit(5'd9, 3'd3, 32'h55);
        rename(5'd9, 3'd6);
        step();
        idle();
        rf.rs2_in = 5'd9;
        #1;
        chk("same_x9_value", rf.rs2_value_out, 32'h55);
        chk("same_x9_busy",  32'(rf.rs2_busy_out), 32'h1);
        chk("same_x9_tag",   32'(rf.rs2_tag_out), 32'h6);

        // Flush with same-cycle rename and commit.
        rename(5'd1, 3'd0);
        step();
        rename(5'd2, 3'd1);
        step();
        idle();
        rf.rs1_in = 5'd1;
        rf.rs2_in = 5'd2;
        #1;
        chk("pre_flush_x1_busy", 32'(rf.rs1_busy_out), 32'h1);
        chk("pre_flush_x2_busy", 32'(rf.rs2_busy_out), 32'h1);
        flush_in = 1'b1;
        rename(5'd4, 3'd2);
        commit(5'd5, 3'd7, 32'h99);
        step();
        idle();
        #1;
        chk("flush_x1_busy", 32'(rf.rs1_busy_out), 32'h0);
        chk("flush_x2_busy", 32'(rf.rs2_busy_out), 32'h0);
        rf.rs1_in = 5'd4;
        rf.rs2_in = 5'd5;
        #1;
        chk("flush_x4_busy",  32'(rf.rs1_busy_out), 32'h0);
        chk("flush_x5_value", rf.rs2_value_out, 32'h99);
        rf.rs2_in = 5'd9;
        #1;
        chk("flush_x9_busy", 32'(rf.rs2_busy_out), 32'h0);

        // x0 ignores renames and commits.
        rename(5'd0, 3'd5);
        commit(5'd0, 3'd0, 32'h123);
        rf.rs1_in = 5'd0;
        #1;
        chk("x0_same_value", rf.rs1_value_out, 32'h0);
        chk("x0_same_busy",  32'(rf.rs1_busy_out), 32'h0);
        step();
        idle();
        #1;
        chk("x0_value", rf.rs1_value_out, 32'h0);
        chk("x0_busy",  32'(rf.rs1_busy_out), 32'h0);
        chk("x0_tag",   32'(rf.rs1_tag_out), 32'h0);

        // rdy_in low freezes state.
        rdy_in = 1'b0;
        rename(5'd6, 3'd3);
        commit(5'd3, 3'd2, 32'hCAFE0000);
        step();
        idle();
        rdy_in    = 1'b1;
        rf.rs1_in = 5'd6;
        rf.rs2_in = 5'd3;
        #1;
        chk("rdy_x6_busy",  32'(rf.rs1_busy_out), 32'h0);
        chk("rdy_x6_tag",   32'(rf.rs1_tag_out), 32'h0);
        chk("rdy_x3_value", rf.rs2_value_out, 32'hDEADBEEF);

        // Reset mid-operation clears values, not just renames.
        rst_in = 1'b1;
        step();
        rst_in    = 1'b0;
        rf.rs1_in = 5'd7;
        rf.rs2_in = 5'd3;
        #1;
        chk("rst2_x7_value", rf.rs1_value_out, 32'h0);
        chk("rst2_x3_value", rf.rs2_value_out, 32'h0);
        rf.rs1_in = 5'd9;
        #1;
        chk("rst2_x9_busy", 32'(rf.rs1_busy_out), 32'h0);
        chk("rst2_x9_tag",  32'(rf.rs1_tag_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename tags for the out-of-order core. It sits between the Decoder/Dispatcher and the RoB:
- the dispatcher reads operands and renames destination registers;
- the RoB writes committed results back and releases tags.

It holds 32 × 32-bit values plus a busy bit and a RoB tag per register. On flush it drops all in-flight renames.

## Interface
- RoB_WIDTH, default 3: RoB index width; tags are RoB_WIDTH bits.
- REG_WIDTH, default 5: register index width, giving 32 registers.
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  reset, synchronous and active-high.
- rdy_in  input  1  global enable; when low, no state changes.
- flush_in  input  1  misprediction flush from the RoB; clears all busy bits.
- commit_valid_in  input  1  RoB commits an instruction with a destination register.
- commit_rd_in  input  REG_WIDTH  committed destination register.
- commit_value_in  input  32  committed result.
- commit_rob_id_in  input  RoB_WIDTH  RoB entry of the committing instruction.
- rename_valid_in  input  1  dispatcher issues an instruction that writes rd.
- rename_rd_in  input  REG_WIDTH  destination register being renamed.
- rename_rob_id_in  input  RoB_WIDTH  RoB entry allocated to it.
- rs1_in, rs2_in  input  REG_WIDTH  source register indices.
- rs1_value_out, rs2_value_out  output  32  register value, or forwarded commit value.
- rs1_busy_out, rs2_busy_out  output  1  operand still pending in the RoB.
- rs1_tag_out, rs2_tag_out  output  RoB_WIDTH  RoB entry that will produce the operand; valid when busy.

## Operation
- **State:** value[32], busy[32], tag[32].
- **Register x0:** always value 0, busy 0, tag 0. Commits and renames targeting x0 are ignored.
- **Commit** (commit_valid_in, rd≠0):
  - value[rd] ← commit_value_in, unconditionally.
  - busy[rd] ← 0 only if tag[rd]==commit_rob_id_in and no rename of the same rd occurs in that cycle.
- **Rename** (rename_valid_in, rd≠0, flush_in low): busy[rd] ← 1 and tag[rd] ← rename_rob_id_in.
- **Commit and rename to the same rd in one cycle:** the value is written, and busy/tag take the rename.
- **Flush cycle:** all busy ← 0 and tags are left stale. A commit in the same cycle still writes its value, and a rename in the same cycle is discarded.
- **Read (combinational):**
  - Base result: value/busy/tag of rs.
  - Forwarding: if commit_valid_in, commit_rd_in==rs≠0, busy[rs] and tag[rs]==commit_rob_id_in, then busy_out=0 and value_out=commit_value_in.
  - The reader's own rename in the same cycle does not affect its reads.
- **rdy_in low:** commit, rename and flush have no effect. Reads still reflect current state.

## Timing
- Reads have zero latency, combinational from rs and the commit inputs.
- Commit, rename and flush are visible on reads in the cycle after the edge that samples them.
- **Reset:** all values 0, busy 0, tags 0. With rs1_in=rs2_in=0, every output is 0.
- rst_in has priority over flush_in, which has priority over rename/commit.
- Reset mid-operation discards all values, not just renames.
- **Stale commit** (tag mismatch because a newer rename happened): the value is written but busy stays set. Later readers wait for the newer tag.
- **Tag wrap-around:** tags compare by RoB index only. The RoB guarantees an index is not reallocated before its commit.

## Structure
- RoB_WIDTH, the register count and the x0 index belong in the shared core defines header used by RoB, dispatcher and RS/LSB.
- Sub-module reg_read_port: one lookup plus commit-forwarding path, instantiated twice (rs1, rs2).
- The state arrays and update logic stay in register_file.

## Test plan
- **Reset:** assert rst_in for 1 cycle, read rs1=5, rs2=0 → values 0, busy 0, tags 0.
- **Rename then commit:**
  - Rename x3→tag 2; next cycle rs1=3 → busy 1, tag 2.
  - Commit x3, id 2, value 0xDEADBEEF; same cycle rs1=3 → busy 0, value 0xDEADBEEF (forwarded).
  - Next cycle → same, read from state.
- **Stale commit:**
  - Rename x7→1, then x7→4.
  - Commit x7, id 1, value 0x11 → value 0x11 stored, busy 1, tag 4.
  - Commit id 4, value 0x22 → busy 0, value 0x22.
- **Simultaneous commit and rename of x9:**
  - Tag 3 pending; commit id 3, value 0x55 and rename x9→tag 6 in the same cycle.
  - Next cycle → value 0x55, busy 1, tag 6.
- **Flush:**
  - Renames x1→0 and x2→1 pending; flush_in with a same-cycle rename x4→2 and commit x5 value 0x99.
  - Next cycle → busy 0 for x1, x2, x4; value[5]=0x99.
- **x0 and rdy_in:**
  - Rename x0 and commit x0 value 0x123 → rs=0 reads 0, not busy.
  - Rename x6 with rdy_in=0 → x6 not busy next cycle.
